// File: rtl/arch_state_checker_if.sv
// Rename-table / PRF lookup port bundle for arch_state_checker.
// master = checker side, slave = core side (rename table + register file).
interface arch_state_checker_if #(
   parameter int ARCH_REGS = 8,
   parameter int PREG_W    = 5,
   parameter int DATA_W    = 16
);
   // Fixed-latency lookup with no valid/ready handshake:
   // - rat_preg_i is a combinational answer to rat_idx_o in the same cycle.
   // - prf_data_i is valid the cycle after prf_addr_o is presented.
   logic [$clog2(ARCH_REGS)-1:0] rat_idx_o;
   logic [PREG_W-1:0]            rat_preg_i;
   logic [PREG_W-1:0]            prf_addr_o;
   logic [DATA_W-1:0]            prf_data_i;

   modport master (output rat_idx_o, prf_addr_o, input rat_preg_i, prf_data_i);
   modport slave  (input rat_idx_o, prf_addr_o, output rat_preg_i, prf_data_i);
endinterface

// File: rtl/arch_state_checker.sv
// After a core stop, walks every architectural register through RAT -> PRF and
// compares it with a loaded expected value. Mismatch log: ARCH_CHK_MISMATCH_LOG_EN.
module arch_state_checker #(
   parameter int ARCH_REGS    = 8,
   parameter int PREG_W       = 5,
   parameter int DATA_W       = 16,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stop_i,
   input  logic                           clear_i,
   input  logic                           ref_we_i,
   input  logic [$clog2(ARCH_REGS)-1:0]   ref_addr_i,
   input  logic [DATA_W-1:0]              ref_data_i,
   arch_state_checker_if.master           lk,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           pass_o,
   output logic [$clog2(ARCH_REGS+1)-1:0] wrong_cnt_o,
   output logic [$clog2(ARCH_REGS)-1:0]   first_bad_o,
   output logic                           mis_valid_o,
   output logic [$clog2(ARCH_REGS)-1:0]   mis_idx_o,
   output logic [DATA_W-1:0]              mis_got_o,
   output logic [DATA_W-1:0]              mis_exp_o,
   output logic [2:0]                     state_dbg_o
);
   localparam int IDX_W = $clog2(ARCH_REGS);
   localparam int CNT_W = $clog2(ARCH_REGS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_LOOKUP, S_READ, S_COMPARE, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [7:0]        drain_cnt;
   logic [IDX_W-1:0]  idx;
   logic [PREG_W-1:0] preg_q;
   logic [CNT_W-1:0]  wrong_cnt;
   logic [IDX_W-1:0]  first_bad;
   logic [DATA_W-1:0] exp_mem [ARCH_REGS];
   logic              last_idx;
   logic              mismatch;

   assign last_idx = (idx == IDX_W'(ARCH_REGS - 1));
   // Case-inequality so an X/Z on the read data is flagged in simulation.
   assign mismatch = (state == S_COMPARE) && (lk.prf_data_i !== exp_mem[idx]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (stop_i) state_nxt = S_DRAIN;
         S_DRAIN:   if (drain_cnt == 8'd0) state_nxt = S_LOOKUP;
         S_LOOKUP:  state_nxt = S_READ;
         S_READ:    state_nxt = S_COMPARE;
         S_COMPARE: state_nxt = last_idx ? S_DONE : S_LOOKUP;
         S_DONE:    if (clear_i) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_cnt <= '0;
         idx       <= '0;
         preg_q    <= '0;
         wrong_cnt <= '0;
         first_bad <= '0;
      end else begin
         case (state)
            S_IDLE: if (stop_i) begin
               drain_cnt <= 8'(DRAIN_CYCLES - 1);
               idx       <= '0;
               wrong_cnt <= '0;
               first_bad <= '0;
            end
            S_DRAIN:  if (drain_cnt != 8'd0) drain_cnt <= drain_cnt - 8'd1;
            S_LOOKUP: preg_q <= lk.rat_preg_i;
            S_COMPARE: begin
               if (mismatch) begin
                  if (wrong_cnt < CNT_W'(ARCH_REGS)) wrong_cnt <= wrong_cnt + CNT_W'(1);
                  if (wrong_cnt == '0) first_bad <= idx;
               end
               if (!last_idx) idx <= idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Expected values deliberately survive reset; loads only while not scanning.
   always_ff @(posedge clk) begin
      if (ref_we_i && (state == S_IDLE || state == S_DONE))
         exp_mem[ref_addr_i] <= ref_data_i;
   end

   assign lk.rat_idx_o  = (state == S_LOOKUP) ? idx : '0;
   assign lk.prf_addr_o = (state == S_READ) ? preg_q : '0;
   assign busy_o        = (state == S_DRAIN) || (state == S_LOOKUP) ||
                          (state == S_READ)  || (state == S_COMPARE);
   assign done_o        = (state == S_DONE);
   assign pass_o        = done_o && (wrong_cnt == '0);
   assign wrong_cnt_o   = wrong_cnt;
   assign first_bad_o   = first_bad;
   assign state_dbg_o   = state;

`ifdef ARCH_CHK_MISMATCH_LOG_EN
   logic              mis_valid_q;
   logic [IDX_W-1:0]  mis_idx_q;
   logic [DATA_W-1:0] mis_got_q;
   logic [DATA_W-1:0] mis_exp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_valid_q <= 1'b0;
         mis_idx_q   <= '0;
         mis_got_q   <= '0;
         mis_exp_q   <= '0;
      end else begin
         mis_valid_q <= mismatch;
         if (mismatch) begin
            mis_idx_q <= idx;
            mis_got_q <= lk.prf_data_i;
            mis_exp_q <= exp_mem[idx];
         end
      end
   end

   assign mis_valid_o = mis_valid_q;
   assign mis_idx_o   = mis_idx_q;
   assign mis_got_o   = mis_got_q;
   assign mis_exp_o   = mis_exp_q;
`else
   assign mis_valid_o = 1'b0;
   assign mis_idx_o   = '0;
   assign mis_got_o   = '0;
   assign mis_exp_o   = '0;
`endif
endmodule

// File: tb/tb_arch_state_checker.sv
// Bench for arch_state_checker: default instance plus a 32-register instance,
// reference model of the scan result, scoreboard queues and a negedge monitor.
module tb_arch_state_checker;
   localparam int N = 8, PW = 5, DW = 16, D = 4;
   localparam int N2 = 32, PW2 = 7, DW2 = 32, D2 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- default instance ----------------
   logic          stop = 0, clear = 0, ref_we = 0;
   logic [2:0]    ref_addr = '0;
   logic [DW-1:0] ref_data = '0;
   logic          busy, done, pass, mis_valid;
   logic [3:0]    wrong_cnt;
   logic [2:0]    first_bad, mis_idx, state_dbg;
   logic [DW-1:0] mis_got, mis_exp;

   arch_state_checker_if #(.ARCH_REGS(N), .PREG_W(PW), .DATA_W(DW)) lk();

   arch_state_checker #(.ARCH_REGS(N), .PREG_W(PW), .DATA_W(DW), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst(rst_n), .stop_i(stop), .clear_i(clear), .ref_we_i(ref_we),
      .ref_addr_i(ref_addr), .ref_data_i(ref_data), .lk(lk), .busy_o(busy),
      .done_o(done), .pass_o(pass), .wrong_cnt_o(wrong_cnt), .first_bad_o(first_bad),
      .mis_valid_o(mis_valid), .mis_idx_o(mis_idx), .mis_got_o(mis_got),
      .mis_exp_o(mis_exp), .state_dbg_o(state_dbg));

   logic [DW-1:0] exp_ref [N];
   logic [PW-1:0] rat_map [N];
   logic [DW-1:0] prf_mem [2**PW];

   assign lk.rat_preg_i = rat_map[lk.rat_idx_o];
   always @(posedge clk) lk.prf_data_i <= prf_mem[lk.prf_addr_o];

   // ---------------- 32-register instance ----------------
   logic           stop2 = 0, clear2 = 0, ref_we2 = 0;
   logic [4:0]     ref_addr2 = '0;
   logic [DW2-1:0] ref_data2 = '0;
   logic           busy2, done2, pass2, mis_valid2;
   logic [5:0]     wrong_cnt2;
   logic [4:0]     first_bad2, mis_idx2;
   logic [DW2-1:0] mis_got2, mis_exp2;
   logic [2:0]     state_dbg2;

   arch_state_checker_if #(.ARCH_REGS(N2), .PREG_W(PW2), .DATA_W(DW2)) lk2();

   arch_state_checker #(.ARCH_REGS(N2), .PREG_W(PW2), .DATA_W(DW2), .DRAIN_CYCLES(D2)) dut2 (
      .clk(clk), .rst(rst_n), .stop_i(stop2), .clear_i(clear2), .ref_we_i(ref_we2),
      .ref_addr_i(ref_addr2), .ref_data_i(ref_data2), .lk(lk2), .busy_o(busy2),
      .done_o(done2), .pass_o(pass2), .wrong_cnt_o(wrong_cnt2), .first_bad_o(first_bad2),
      .mis_valid_o(mis_valid2), .mis_idx_o(mis_idx2), .mis_got_o(mis_got2),
      .mis_exp_o(mis_exp2), .state_dbg_o(state_dbg2));

   logic [DW2-1:0] exp2_ref [N2];
   logic [DW2-1:0] prf2_mem [2**PW2];

   assign lk2.rat_preg_i = {2'b10, lk2.rat_idx_o};  // arch i -> preg i+64
   always @(posedge clk) lk2.prf_data_i <= prf2_mem[lk2.prf_addr_o];

   // ---------------- scoreboard ----------------
   logic [39:0] exp_q [$];   // {start_cycle, wrong_cnt, first_bad, pass}
   logic [34:0] mis_q [$];   // {idx, got, exp}
   logic [44:0] exp2_q [$];  // {start_cycle, wrong_cnt, first_bad, pass}
   int scan_start = -1;
   logic [39:0] e1;
   logic [34:0] m1;
   logic [44:0] e2;
   logic done_d = 0, done2_d = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
`ifdef ARCH_CHK_MISMATCH_LOG_EN
         if (mis_valid) begin
            if (mis_q.size() == 0) chk("mis_unexpected", 1, 0);
            else begin
               m1 = mis_q.pop_front();
               chk("mis_idx", mis_idx, m1[34:32]);
               chk("mis_got", mis_got, m1[31:16]);
               chk("mis_exp", mis_exp, m1[15:0]);
            end
         end
`endif
         if (done && !done_d) begin
            if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e1 = exp_q.pop_front();
               chk("wrong_cnt", wrong_cnt, e1[7:4]);
               chk("first_bad", first_bad, e1[3:1]);
               chk("pass", pass, e1[0]);
               chk("latency", cyc - int'(e1[39:8]), D + 3 * N);
            end
`ifdef ARCH_CHK_MISMATCH_LOG_EN
            chk("mis_pending", mis_q.size(), 0);
`else
            chk("mis_tied", {mis_valid, mis_idx, mis_got, mis_exp}, 0);
            mis_q.delete();
`endif
         end
         if (scan_start >= 0 && cyc - scan_start >= 0 && cyc - scan_start < D + 3 * N) begin
            int ph, k, r;
            ph = cyc - scan_start;
            chk("busy_scan", busy, 1);
            chk("done_early", done, 0);
            if (ph >= D) begin
               k = (ph - D) / 3;
               r = (ph - D) % 3;
               chk("rat_idx", lk.rat_idx_o, (r == 0) ? k : 0);
               chk("prf_addr", lk.prf_addr_o, (r == 1) ? rat_map[k] : 0);
            end else begin
               chk("rat_idx_drain", lk.rat_idx_o, 0);
               chk("prf_addr_drain", lk.prf_addr_o, 0);
            end
         end
         if (done2 && !done2_d) begin
            if (exp2_q.size() == 0) chk("done2_unexpected", 1, 0);
            else begin
               e2 = exp2_q.pop_front();
               chk("wrong_cnt2", wrong_cnt2, e2[11:6]);
               chk("first_bad2", first_bad2, e2[5:1]);
               chk("pass2", pass2, e2[0]);
               chk("latency2", cyc - int'(e2[44:12]), D2 + 3 * N2);
            end
         end
      end
      done_d  = done;
      done2_d = done2;
   end

   // ---------------- driver tasks (entered and left on a negedge) ----------------
   task automatic load_ref(input int a, input logic [DW-1:0] d, input bit accepted);
      ref_we = 1; ref_addr = 3'(a); ref_data = d;
      @(negedge clk);
      ref_we = 0;
      if (accepted) exp_ref[a] = d;
   endtask

   // Reference result: read each arch register through the modelled RAT/PRF.
   task automatic start_scan(input bit hold);
      int cnt, fb;
      logic [DW-1:0] got;
      cnt = 0; fb = 0;
      for (int i = 0; i < N; i++) begin
         got = prf_mem[rat_map[i]];
         if (got !== exp_ref[i]) begin
            if (cnt == 0) fb = i;
            cnt++;
            mis_q.push_back({3'(i), got, exp_ref[i]});
         end
      end
      stop = 1;
      scan_start = cyc + 1;
      exp_q.push_back({32'(scan_start), 4'(cnt), 3'(fb), cnt == 0});
      if (!hold) begin
         @(negedge clk);
         stop = 0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic clear_scan();
      clear = 1;
      @(negedge clk);
      clear = 0;
      scan_start = -1;
      @(negedge clk);
   endtask

   task automatic chk_idle(input string name);
      chk(name, {busy, done, pass, wrong_cnt, first_bad, mis_valid, lk.rat_idx_o, lk.prf_addr_o}, 0);
   endtask

   initial begin
      for (int i = 0; i < 2**PW; i++) prf_mem[i] = '0;
      for (int i = 0; i < N; i++) begin exp_ref[i] = '0; rat_map[i] = '0; end
      #1;
      chk_idle("reset_outputs");
      chk("reset_outputs2", {busy2, done2, pass2, wrong_cnt2, first_bad2}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk_idle("idle_after_reset");

      // Matching scan: expected 1..8, arch i -> preg i+8
      for (int i = 0; i < N; i++) begin
         load_ref(i, DW'(i + 1), 1);
         rat_map[i] = PW'(i + 8);
         prf_mem[i + 8] = DW'(i + 1);
      end
      start_scan(0); wait_done(); clear_scan();

      // Two corrupted physical registers
      prf_mem[11] = 16'hFFFF; prf_mem[14] = 16'h0000;
      start_scan(0); wait_done(); clear_scan();
      prf_mem[11] = 16'h0004; prf_mem[14] = 16'h0007;

      // Load attempt during DRAIN must be ignored
      start_scan(0);
      load_ref(0, 16'hDEAD, 0);
      wait_done(); clear_scan();

      // Reset in the READ cycle of index 5, then a fresh full scan
      start_scan(0);
      while (cyc - scan_start < D + 3 * 5 + 1) @(negedge clk);
      chk("prf_addr_before_reset", lk.prf_addr_o, rat_map[5]);
      scan_start = -1; exp_q.delete(); mis_q.delete();
      rst_n = 0;
      #1;
      chk_idle("async_reset_midscan");
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk_idle("idle_after_midscan_reset");
      start_scan(0); wait_done(); clear_scan();

      // stop held across scan and DONE; clear wins over stop
      start_scan(1); wait_done();
      repeat (2) @(negedge clk);
      chk("done_held", {done, busy}, 2'b10);
      clear = 1;
      @(negedge clk);
      clear = 0; stop = 0; scan_start = -1;
      chk("idle_after_clear", {busy, done}, 0);
      repeat (4) @(negedge clk);
      chk("no_restart", {busy, done}, 0);

      // Randomized scans
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < N; i++) begin
            load_ref(i, DW'($urandom_range(0, 65535)), 1);
            rat_map[i] = PW'($urandom_range(0, 2**PW - 1));
         end
         for (int i = 0; i < N; i++)
            prf_mem[rat_map[i]] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 65535)) : exp_ref[i];
         start_scan(0); wait_done();
         load_ref(7, DW'($urandom_range(0, 65535)), 1);  // load accepted in DONE
         clear_scan();
      end
      start_scan(0); wait_done(); clear_scan();

      // 32-register instance, every register wrong
      for (int i = 0; i < N2; i++) begin
         exp2_ref[i] = $urandom;
         prf2_mem[i + 64] = ~exp2_ref[i];
         ref_we2 = 1; ref_addr2 = 5'(i); ref_data2 = exp2_ref[i];
         @(negedge clk);
      end
      ref_we2 = 0;
      stop2 = 1;
      exp2_q.push_back({33'(cyc + 1), 6'(32), 5'(0), 1'b0});
      @(negedge clk);
      stop2 = 0;
      begin
         int n;
         n = 0;
         while (!done2 && n < 300) begin @(negedge clk); n++; end
         if (!done2) chk("done2_timeout", 0, 1);
      end
      @(negedge clk);
      chk("sb_empty", exp_q.size() + exp2_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
